// File: rtl/seg_595_scan.sv
// seg_595_scan: multiplexes six 7-segment digits through two cascaded 74HC595s.
// Each frame shifts {segment pattern, one-hot digit select} out MSB first,
// pulses the storage latch, then idles before moving on to the next digit.
module seg_595_scan #(
   parameter int DIV      = 2,
   parameter int SCAN_DIV = 50000
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [47:0] seg_code,
   input  logic        disp_en,
   output logic        data_ser,
   output logic        srclk,
   output logic        rclk,
   output logic        busy
);

   localparam int             IW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [IW-1:0]  IDLE_LAST = IW'(SCAN_DIV - 1);
   localparam logic [7:0]     PH_LAST   = 8'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_idleCnt;
   logic [7:0]      r_phase;
   logic            r_half;
   logic [3:0]      r_bitCnt;
   logic [15:0]     r_frame;
   logic [2:0]      r_idx;
   logic            r_dataSer;
   logic            r_srclk;
   logic            r_rclk;
   logic            r_busy;

   logic [7:0]      w_digit;
   logic [7:0]      w_sel;
   logic [15:0]     w_frame;

   // Pick the current digit's pattern and its one-hot select (all off when blanked)
   always_comb begin
      w_digit = 8'h00;
      w_sel   = 8'h00;
      case (r_idx)
         3'd0: begin w_digit = seg_code[7:0];   w_sel = 8'h01; end
         3'd1: begin w_digit = seg_code[15:8];  w_sel = 8'h02; end
         3'd2: begin w_digit = seg_code[23:16]; w_sel = 8'h04; end
         3'd3: begin w_digit = seg_code[31:24]; w_sel = 8'h08; end
         3'd4: begin w_digit = seg_code[39:32]; w_sel = 8'h10; end
         3'd5: begin w_digit = seg_code[47:40]; w_sel = 8'h20; end
         default: begin w_digit = 8'h00; w_sel = 8'h00; end
      endcase
      if (!disp_en) begin
         w_sel = 8'h00;
      end
      w_frame = {w_digit, w_sel};
   end

   // Scan sequencer: idle wait, 16-bit serial shift, latch pulse, advance digit
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state   <= IDLE;
         r_idleCnt <= '0;
         r_phase   <= 8'd0;
         r_half    <= 1'b0;
         r_bitCnt  <= 4'd0;
         r_frame   <= 16'h0000;
         r_idx     <= 3'd0;
         r_dataSer <= 1'b0;
         r_srclk   <= 1'b0;
         r_rclk    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_idleCnt == IDLE_LAST) begin
                  r_idleCnt <= '0;
                  r_state   <= SHIFT;
                  r_dataSer <= w_frame[15];
                  r_frame   <= {w_frame[14:0], 1'b0};
                  r_busy    <= 1'b1;
                  r_phase   <= 8'd0;
                  r_half    <= 1'b0;
                  r_bitCnt  <= 4'd0;
               end else begin
                  r_idleCnt <= r_idleCnt + 1'b1;
               end
            end
            SHIFT: begin
               if (r_phase != PH_LAST) begin
                  r_phase <= r_phase + 8'd1;
               end else begin
                  r_phase <= 8'd0;
                  if (!r_half) begin
                     r_half  <= 1'b1;
                     r_srclk <= 1'b1;
                  end else begin
                     r_half  <= 1'b0;
                     r_srclk <= 1'b0;
                     if (r_bitCnt == 4'd15) begin
                        r_state   <= LATCH;
                        r_rclk    <= 1'b1;
                        r_dataSer <= 1'b0;
                        r_bitCnt  <= 4'd0;
                     end else begin
                        r_bitCnt  <= r_bitCnt + 4'd1;
                        r_dataSer <= r_frame[15];
                        r_frame   <= {r_frame[14:0], 1'b0};
                     end
                  end
               end
            end
            LATCH: begin
               if (r_phase != PH_LAST) begin
                  r_phase <= r_phase + 8'd1;
               end else begin
                  r_phase <= 8'd0;
                  if (!r_half) begin
                     r_half <= 1'b1;
                     r_rclk <= 1'b0;
                  end else begin
                     r_half  <= 1'b0;
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     r_idx   <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign data_ser = r_dataSer;
   assign srclk    = r_srclk;
   assign rclk     = r_rclk;
   assign busy     = r_busy;

endmodule

// File: tb/tb_seg_595_scan.sv
// Testbench for seg_595_scan with DIV=2, SCAN_DIV=50.
// A monitor reassembles each shifted frame and pops the expected word from a
// scoreboard queue at every latch pulse; it also tracks bit timing and period.
module tb_seg_595_scan;

   localparam int DIV      = 2;
   localparam int SCAN_DIV = 50;
   localparam int PERIOD   = SCAN_DIV + 34 * DIV;

   logic        sys_clk;
   logic        sys_rst_n;
   logic [47:0] seg_code;
   logic        disp_en;
   logic        data_ser;
   logic        srclk;
   logic        rclk;
   logic        busy;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] expQ[$];

   typedef struct {
      logic [47:0] seg;
      logic        en;
      logic [15:0] expWord;
   } vec_t;

   vec_t vecs[9];

   seg_595_scan #(.DIV(DIV), .SCAN_DIV(SCAN_DIV)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .seg_code  (seg_code),
      .disp_en   (disp_en),
      .data_ser  (data_ser),
      .srclk     (srclk),
      .rclk      (rclk),
      .busy      (busy)
   );

   // 100 MHz-style free-running system clock
   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   // Hard stop in case something wedges completely
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [47:0] seg, input logic en);
      seg_code = seg;
      disp_en  = en;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge sys_clk);
      #2;
   endtask

   task automatic waitBusy(input logic level, input string what);
      for (int n = 0; n < 400; n++) begin
         @(posedge sys_clk);
         #2;
         if (busy == level) return;
      end
      checkOutput(what, 32'(busy), 32'(level));
   endtask

   // Monitor state
   int          cyc = 0;
   int          lastBusyRise = -1;
   int          lowStart = 0;
   int          highStart = 0;
   int          rclkStart = 0;
   int          rclkCount = 0;
   int          bitsSeen = 0;
   int          viol = 0;
   logic [15:0] word = 16'h0;
   logic        prevData = 1'b0;
   logic        prevSrclk = 1'b0;
   logic        prevRclk = 1'b0;
   logic        prevBusy = 1'b0;

   // Sample every cycle 1 time unit after the edge, rebuild frames, score them
   always begin
      logic srRise, srFall, bRise, rRise, rFall;
      logic [15:0] expWord;
      @(posedge sys_clk);
      #1;
      cyc++;
      if (!sys_rst_n) begin
         bitsSeen     = 0;
         word         = 16'h0;
         lastBusyRise = -1;
         viol         = 0;
      end else begin
         srRise = srclk && !prevSrclk;
         srFall = !srclk && prevSrclk;
         bRise  = busy && !prevBusy;
         rRise  = rclk && !prevRclk;
         rFall  = !rclk && prevRclk;
         if ((data_ser != prevData) && !(srFall || bRise)) viol++;
         if (srclk && rclk) viol++;
         if (rclk && data_ser) viol++;
         if (srclk && !busy) viol++;
         if (bRise) begin
            if (lastBusyRise >= 0) checkOutput("period", 32'(cyc - lastBusyRise), 32'(PERIOD));
            lastBusyRise = cyc;
            lowStart     = cyc;
            bitsSeen     = 0;
            word         = 16'h0;
         end
         if (srFall) begin
            if (cyc - highStart != DIV) viol++;
            lowStart = cyc;
         end
         if (srRise) begin
            if (cyc - lowStart != DIV) viol++;
            highStart = cyc;
            word      = {word[14:0], data_ser};
            bitsSeen++;
         end
         if (rRise) begin
            rclkCount++;
            rclkStart = cyc;
            if (expQ.size() == 0) begin
               checkOutput("latchWithEmptyQueue", 32'd1, 32'd0);
            end else begin
               expWord = expQ.pop_front();
               checkOutput("frame", 32'(word), 32'(expWord));
            end
            checkOutput("bitCount", 32'(bitsSeen), 32'd16);
            checkOutput("timing", 32'(viol), 32'd0);
            viol = 0;
         end
         if (rFall) checkOutput("rclkWidth", 32'(cyc - rclkStart), 32'(DIV));
      end
      prevData  = data_ser;
      prevSrclk = srclk;
      prevRclk  = rclk;
      prevBusy  = busy;
   end

   // Main stimulus sequence
   initial begin
      int latency;
      int rclkBefore;

      vecs[0] = '{48'h151413121110, 1'b1, 16'h1001};
      vecs[1] = '{48'h151413121110, 1'b1, 16'h1102};
      vecs[2] = '{48'h151413121110, 1'b1, 16'h1204};
      vecs[3] = '{48'h151413121110, 1'b1, 16'h1308};
      vecs[4] = '{48'h151413121110, 1'b1, 16'h1410};
      vecs[5] = '{48'h151413121110, 1'b1, 16'h1520};
      vecs[6] = '{48'h151413121110, 1'b1, 16'h1001};
      vecs[7] = '{48'hFFFFFFFFFFFF, 1'b0, 16'hFF00};
      vecs[8] = '{48'hFFFFFFFFFFFF, 1'b1, 16'hFF04};

      sys_rst_n = 1'b0;
      applyStimulus(vecs[0].seg, vecs[0].en);
      waitCycles(3);
      checkOutput("resetOutputs", {28'h0, data_ser, srclk, rclk, busy}, 32'h0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      // Table: seven scanned frames, then a blanked frame and its follower
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].seg, vecs[i].en);
         expQ.push_back(vecs[i].expWord);
         waitBusy(1'b1, "tableBusyRise");
         waitBusy(1'b0, "tableBusyFall");
      end

      // Changing the pattern mid-shift must only show up in the next visit
      applyStimulus(48'h0000AA000000, 1'b1);
      expQ.push_back(16'hAA08);
      expQ.push_back(16'h0010);
      expQ.push_back(16'h0020);
      expQ.push_back(16'h0001);
      expQ.push_back(16'h0002);
      expQ.push_back(16'h0004);
      expQ.push_back(16'h5508);
      waitBusy(1'b1, "midShiftBusyRise");
      waitCycles(10);
      applyStimulus(48'h000055000000, 1'b1);
      waitBusy(1'b0, "midShiftBusyFall");
      for (int f = 0; f < 6; f++) begin
         waitBusy(1'b1, "followBusyRise");
         waitBusy(1'b0, "followBusyFall");
      end

      // Abort a frame at bit 8 with reset; no latch pulse may follow
      applyStimulus(48'h000000000000, 1'b1);
      waitBusy(1'b1, "abortBusyRise");
      waitCycles(32);
      rclkBefore = rclkCount;
      sys_rst_n  = 1'b0;
      #1;
      checkOutput("abortOutputs", {28'h0, data_ser, srclk, rclk, busy}, 32'h0);
      waitCycles(5);
      checkOutput("abortHeldOutputs", {28'h0, data_ser, srclk, rclk, busy}, 32'h0);
      checkOutput("noLatchOnAbort", 32'(rclkCount), 32'(rclkBefore));

      // After release the first frame is digit 0 after exactly SCAN_DIV idle cycles
      applyStimulus(48'h0000000000C0, 1'b1);
      expQ.push_back(16'hC001);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      latency   = 0;
      for (int n = 0; n < 200; n++) begin
         @(posedge sys_clk);
         #2;
         latency++;
         if (busy) break;
      end
      checkOutput("firstFrameLatency", 32'(latency), 32'(SCAN_DIV));
      waitBusy(1'b0, "restartBusyFall");
      waitCycles(5);

      checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
      checkOutput("timingTail", 32'(viol), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_595_scan.md
SEG_595_SCAN -- requirements
Module: seg_595_scan

Interface
REQ-001 Parameter DIV, default 2, srclk/rclk half-period in sys_clk cycles (legal range 1..255).
REQ-002 Parameter SCAN_DIV, default 50000, idle cycles between consecutive frames (legal range >= 2).
REQ-003 sys_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 seg_code  input  48  six 8-bit segment patterns; digit k = seg_code[8k+7:8k], bit 7 = dp.
REQ-006 disp_en  input  1  display enable; 0 blanks every digit.
REQ-007 data_ser  output  1  serial data to the first cascaded 74HC595 (SER).
REQ-008 srclk  output  1  shift clock (SRCLK).
REQ-009 rclk  output  1  storage latch clock (RCLK).
REQ-010 busy  output  1  high while a frame is being shifted or latched.

Function
REQ-011 State machine SHALL have exactly three states, IDLE, SHIFT and LATCH, with IDLE as the reset state.
REQ-012 IDLE SHALL count SCAN_DIV cycles and then enter SHIFT; the counter SHALL clear on exit and SHALL not run outside IDLE.
REQ-013 On IDLE->SHIFT the block SHALL capture frame[15:0] = {seg_code digit idx, sel}; later seg_code/disp_en changes SHALL not affect that frame.
REQ-014 sel SHALL be one-hot active-high on bit idx (bits 7:6 always 0), or 8'h00 when disp_en=0 at capture.
REQ-015 SHIFT SHALL emit 16 bits MSB first (frame[15] first); each bit occupies 2*DIV cycles: srclk low DIV cycles, then high DIV cycles.
REQ-016 data_ser SHALL change only while srclk is low and SHALL be stable from the start of the bit until srclk falls again (setup >= DIV cycles, hold >= DIV cycles).
REQ-017 After bit 16's high phase, the block SHALL enter LATCH: rclk high DIV cycles, then low DIV cycles, with srclk low and data_ser 0 throughout.
REQ-018 At LATCH exit, idx SHALL increment 0->1->...->5->0 (wrap after 5) and the FSM SHALL return to IDLE.
REQ-019 busy SHALL be 1 exactly in SHIFT and LATCH.
REQ-020 Frame period SHALL be exactly SCAN_DIV + 34*DIV cycles (118 with DIV=2, SCAN_DIV=50).
REQ-021 disp_en SHALL not stop scanning; a blanked frame still advances idx.
REQ-022 Bit/phase counters SHALL be sized for DIV up to 255 and the shift count 0..15 without overflow.

Reset
REQ-023 While sys_rst_n=0: data_ser=0, srclk=0, rclk=0, busy=0, idx=0, state IDLE, all counters 0.
REQ-024 Reset asserted mid-SHIFT or mid-LATCH SHALL abort the frame immediately (no rclk pulse); after release, the first frame SHALL again be digit 0 after SCAN_DIV idle cycles.

Verification (DIV=2, SCAN_DIV=50)
REQ-025 Release reset, seg_code digit0=8'hC0, disp_en=1 -> busy rises after 50 cycles; serial stream 16'hC001 MSB first sampled on srclk rising edges; one rclk pulse 2 cycles wide.
REQ-026 Run 7 frames with digit k = 8'h10+k -> sel bytes 01,02,04,08,10,20,01; seg bytes 10..15,10; period 118 cycles each.
REQ-027 disp_en=0 at capture, seg=8'hFF -> frame 16'hFF00; idx still advances.
REQ-028 Change seg_code during SHIFT -> current frame unchanged; new value appears in that digit's next frame.
REQ-029 Assert sys_rst_n at bit 8 of a frame -> outputs 0 within the reset, no rclk pulse; after release next frame is digit 0.
REQ-030 Every bit: data_ser stable across each srclk rising edge with >= 2 cycles setup and hold; rclk never high while srclk high.
